regfile_param: RTL and testbench
================================

# regfile_param

Parametrised successor to the current 32×32 register bank: a register file with configurable width and depth, one write port, two synchronous read ports, hardwired zero entry, and a hardware clear sweep. It sits between decode (read addresses) and writeback (write port) in the CPU datapath. It also replaces the external register-destination select: decode drives `wr_addr` directly. Memory contents are never reset asynchronously; a counter-driven sweep zeroes the array after reset or on request.

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, address width; depth is 2**ADDR_WIDTH (derived, not overridable)
- `ZERO_REG`, 1, when 1 entry 0 always reads 0 and ignores writes
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `rd_addr1`  in  ADDR_WIDTH  read port 1 address ($rs)
- `rd_addr2`  in  ADDR_WIDTH  read port 2 address ($rt)
- `rd_data1`  out  DATA_WIDTH  read port 1 data, registered
- `rd_data2`  out  DATA_WIDTH  read port 2 data, registered
- `wr_en`  in  1  write enable
- `wr_addr`  in  ADDR_WIDTH  write address
- `wr_data`  in  DATA_WIDTH  write data
- `clear_req`  in  1  single-cycle pulse requesting a full-array clear
- `busy`  out  1  high while a clear sweep runs; writes are dropped

## Operation
- FSM states: IDLE, CLEAR.
- Reset asserted:
  - state goes to CLEAR; sweep pointer `clr_ptr` goes to 0.
  - `busy` = 1; `rd_data1` = `rd_data2` = 0.
  - Array contents are untouched.
- CLEAR:
  - Each cycle writes 0 to entry `clr_ptr`, then increments `clr_ptr`.
  - When the write to entry 2**ADDR_WIDTH−1 is done, goes to IDLE; `clr_ptr` wraps to 0.
  - `wr_en` is ignored and the write is lost; upstream must stall on `busy`.
  - `clear_req` is ignored (no restart).
  - Read ports register 0.
- IDLE:
  - `wr_en`=1 writes `wr_data` to `wr_addr`, unless `wr_addr`==0 and ZERO_REG=1.
  - `clear_req`=1 goes to CLEAR next cycle. A write in the same cycle is still performed, then cleared by the sweep.
- Reads:
  - Each cycle `rd_dataN` <= array[`rd_addrN`].
  - With ZERO_REG=1, address 0 yields 0.
  - Both ports may read the same address.
- Read-during-write to the same address: result is set by the bypass configuration (see Configuration).
- Reset mid-sweep: the sweep restarts from entry 0.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N+1.
- Write is visible to a non-bypassed read issued the cycle after the write edge.
- Clear sweep:
  - Takes exactly 2**ADDR_WIDTH cycles after `reset_n` deasserts, or after the `clear_req` edge.
  - `busy` falls on the edge that performs the last clear write.
  - The first accepted write is in the following cycle.
- `busy` is a registered output, driven only from FSM state.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `wr_en` && `wr_addr`==`rd_addrN` && write is accepted, `rd_dataN` registers `wr_data` (write-first).
  - Zero-reg and busy rules take precedence over bypass.
- `REGFILE_BYPASS_EN` undefined: same-cycle read returns the old array value (read-first); no forwarding muxes are built.

## Structure
- `regfile_pkg`: FSM state enum (`RF_IDLE`, `RF_CLEAR`), default width/address constants.
- Sub-module `regfile_clear_ctrl`:
  - Contents: FSM, `clr_ptr` counter and `busy`.
  - Outputs: clear-write enable and address, muxed ahead of the array write port.
- Array, read registers and bypass logic stay in `regfile_param`.

## Test plan
- Reset:
  - Release `reset_n`; poll `busy`.
  - Expect `busy`=1 for exactly 32 cycles, then 0.
  - All 32 entries then read 0 on both ports.
- Write/read:
  - After the sweep, write 0xDEADBEEF to r5.
  - Next cycle, `rd_addr1`=5 and `rd_addr2`=5.
  - One cycle later both ports = 0xDEADBEEF.
- Zero register: write 0x12345678 to r0 with ZERO_REG=1; reading r0 returns 0.
- Same-cycle read/write (r7 holds 0x1, write 0x2 to r7 with `rd_addr1`=7):
  - With `REGFILE_BYPASS_EN`: `rd_data1`=0x2.
  - Without it: `rd_data1`=0x1.
- Clear request:
  - Fill r1–r31 with their index.
  - Pulse `clear_req` together with a write of 0xAA to r3.
  - Expect `busy` for 32 cycles.
  - Writes during `busy` are dropped; all entries then read 0.
- Reset mid-sweep:
  - Assert `reset_n`=0 at sweep cycle 10.
  - On release, `busy` lasts a full 32 cycles and outputs are 0 throughout reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear-sweep FSM
// states and default geometry.
package regfile_pkg;

    // Register width and address width of the classic 32x32 bank
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // The array is either usable (IDLE) or being zeroed entry by entry (CLEAR)
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller for the register file. Owns the IDLE/CLEAR FSM,
// the sweep pointer and the registered busy flag. While sweeping it emits
// one zero-write per cycle (enable + address) for the array write mux.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  busy
);

    rf_state_t             state;
    rf_state_t             state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  last_entry;

    assign last_entry = (clr_ptr == {ADDR_WIDTH{1'b1}});
    assign clr_we     = (state == RF_CLEAR);
    assign clr_addr   = clr_ptr;

    // Next state: a request starts a sweep, the last entry ends it;
    // further requests during a sweep are ignored
    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE: begin
                if (clear_req) begin
                    state_next = RF_CLEAR;
                end
            end
            RF_CLEAR: begin
                if (last_entry) begin
                    state_next = RF_IDLE;
                end
            end
            default: begin
                state_next = RF_CLEAR;
            end
        endcase
    end

    // State, sweep pointer and busy; reset always (re)starts a full sweep from entry 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            state <= state_next;
            busy  <= (state_next == RF_CLEAR);
            if (state == RF_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end else begin
                clr_ptr <= '0;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional hardwired-zero entry 0 and a hardware clear sweep after reset or
// on request. Array contents have no reset; the sweep zeroes them.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of a
// same-cycle write to the read ports; otherwise reads are read-first.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_next1;
    logic [DATA_WIDTH-1:0] rd_next2;

    regfile_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .busy      (busy)
    );

    // A user write lands only when no sweep runs and it does not target the zero entry
    always_comb begin
        wr_accept = wr_en && !busy;
        if ((ZERO_REG != 0) && (wr_addr == '0)) begin
            wr_accept = 1'b0;
        end
    end

    // Write-port mux: the clear sweep owns the port while it runs
    always_comb begin
        mem_we    = wr_accept;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    // Array storage, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-port 1 next value: array, optional forwarding, then zero/busy overrides
    always_comb begin
        rd_next1 = mem[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr1)) begin
            rd_next1 = wr_data;
        end
`endif
        if (busy || ((ZERO_REG != 0) && (rd_addr1 == '0))) begin
            rd_next1 = '0;
        end
    end

    // Read-port 2 next value: same rules as port 1
    always_comb begin
        rd_next2 = mem[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr2)) begin
            rd_next2 = wr_data;
        end
`endif
        if (busy || ((ZERO_REG != 0) && (rd_addr2 == '0))) begin
            rd_next2 = '0;
        end
    end

    // Registered read data, forced to zero while reset is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (32x32, ZERO_REG=1). Expected read
// data is queued when the read is issued and compared after the edge that
// registers it. Honours REGFILE_BYPASS_EN for same-cycle read/write cases.
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clear_req = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    regfile_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ZERO_REG   (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear_req (clear_req),
        .busy      (busy)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [AW-1:0] rd_a1;
        logic [AW-1:0] rd_a2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    task automatic compare(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, queue the read results they must produce, clock once
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic creq);
        exp_t e;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr1  = a1;
        rd_addr2  = a2;
        clear_req = creq;
        e.exp1    = e1;
        e.exp2    = e2;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL %s: got empty scoreboard, expected one pending read", name);
        end else begin
            e = sb_q.pop_front();
            compare({name, "/rd1"}, rd_data1, e.exp1);
            compare({name, "/rd2"}, rd_data2, e.exp2);
        end
    endtask

    task automatic idleInputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;
    endtask

    // Count cycles until busy drops, bounded
    task automatic countBusy(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
        compare(name, DW'(n), DW'(DEPTH));
    endtask

    // Read every entry on both ports and expect zero
    task automatic readAllZero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), '0, '0, 1'b0);
            checkOutput(name);
        end
    endtask

    initial begin
        // Stimulus table, consumed in order after the reset sweep
        vecs.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0});
        vecs.push_back('{1'b1, 5'd7,  32'h1,        5'd7,  5'd7,  BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h1, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 5'd7,  32'h2,        5'd7,  5'd5,  BYP ? 32'h2 : 32'h1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2, 32'h2});
        vecs.push_back('{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0,  BYP ? 32'hFFFFFFFF : 32'h0, 32'h0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{1'b0, 5'd7,  32'h55,       5'd7,  5'd31, 32'h2, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2, 32'h2});

        // Reset: outputs zero and busy high while held
        #1 reset_n = 1'b0;
        #12;
        compare("reset_busy", DW'(busy), 32'h1);
        compare("reset_rd1", rd_data1, 32'h0);
        compare("reset_rd2", rd_data2, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare("release_busy", DW'(busy), 32'h1);
        countBusy("reset_sweep_len");
        readAllZero("post_reset_read");

        // Table-driven write/read, zero register and same-cycle read/write
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                          vecs[i].rd_a1, vecs[i].rd_a2, vecs[i].exp1, vecs[i].exp2, 1'b0);
            checkOutput($sformatf("vec%0d", i));
        end

        // Fill r1..r31 with their index and read them back
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b1, AW'(i), DW'(i), '0, '0, '0, '0, 1'b0);
            checkOutput("fill");
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), DW'(i), DW'(DEPTH - 1 - i), 1'b0);
            checkOutput("fill_read");
        end

        // Clear request together with a write to r3; writes during the sweep are dropped
        begin
            int n;
            applyStimulus(1'b1, 5'd3, 32'hAA, 5'd3, 5'd4, BYP ? 32'hAA : 32'h3, 32'h4, 1'b1);
            checkOutput("clear_req_cycle");
            compare("clear_busy_start", DW'(busy), 32'h1);
            n = 0;
            while (busy && n < 100) begin
                applyStimulus(1'b1, AW'(n), 32'hCAFE0000 | DW'(n), AW'(n), 5'd3, '0, '0, (n == 5));
                checkOutput("during_clear");
                n++;
            end
            compare("clear_sweep_len", DW'(n), DW'(DEPTH));
            idleInputs();
            readAllZero("post_clear_read");
        end

        // Reset in the middle of a sweep restarts it from entry 0
        applyStimulus(1'b1, 5'd20, 32'h20, '0, '0, '0, '0, 1'b0);
        checkOutput("pre_mid_w20");
        applyStimulus(1'b1, 5'd9, 32'h9, 5'd20, '0, 32'h20, '0, 1'b0);
        checkOutput("pre_mid_w9");
        idleInputs();
        reset_n = 1'b0;
        #1;
        compare("mid_reset1_busy", DW'(busy), 32'h1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        compare("mid_sweep_busy", DW'(busy), 32'h1);
        rd_addr1 = 5'd20;
        rd_addr2 = 5'd9;
        reset_n  = 1'b0;
        #1;
        compare("mid_reset_busy", DW'(busy), 32'h1);
        compare("mid_reset_rd1", rd_data1, 32'h0);
        compare("mid_reset_rd2", rd_data2, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            compare("held_reset_rd1", rd_data1, 32'h0);
            compare("held_reset_rd2", rd_data2, 32'h0);
            compare("held_reset_busy", DW'(busy), 32'h1);
        end
        reset_n = 1'b1;
        countBusy("mid_reset_sweep_len");
        applyStimulus(1'b0, '0, '0, 5'd20, 5'd9, '0, '0, 1'b0);
        checkOutput("after_mid_reset");
        applyStimulus(1'b0, '0, '0, 5'd31, 5'd1, '0, '0, 1'b0);
        checkOutput("after_mid_reset2");

        compare("scoreboard_drained", DW'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
